if_fetch: RTL
=============

# if_fetch

Instruction-fetch stage of the five-stage pipeline. It sits directly upstream of the IF/ID pipeline register. It owns the program counter and issues one instruction-memory request at a time over a req/ack handshake, buffering the returned word. Each cycle it presents `instr` and `pc_incr` to IF/ID. It honours the hazard unit's `en_IF` stall and the ID-stage branch redirect, and inserts NOP bubbles whenever no valid instruction is available.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset (0 = reset).
- `en_IF`  in  1: 1 = IF/ID captures this cycle; 0 = pipeline stalled.
- `pc_src`  in  1: branch/jump taken in ID; redirect fetch to `branch_target`.
- `branch_target`  in  32: redirect address, word-aligned.
- `imem_req`  out  1: memory request valid.
- `imem_addr`  out  32: request address.
- `imem_ack`  in  1: memory returns `imem_rdata` this cycle and completes the request.
- `imem_rdata`  in  32: instruction word, valid only with `imem_ack`.
- `instr`  out  32: instruction to IF/ID; 32'h0 (NOP) when `fetch_valid`=0.
- `pc_incr`  out  32: PC+4 of the current fetch PC.
- `fetch_valid`  out  1: `instr` is a real instruction this cycle.

## Operation
- State: `pc` (32), `buf` (32), `buf_valid`, `drain_addr` (32), and FSM {IDLE, REQ, DRAIN}.
- IDLE (reset state):
  - `imem_req`=0.
  - Next cycle goes to REQ.
- REQ:
  - `imem_req`=1 when `buf_valid`=0; `imem_addr`=`pc`.
  - `imem_req`=0 while `buf_valid`=1.
- DRAIN:
  - `imem_req`=1; `imem_addr`=`drain_addr`.
  - Returned data is discarded.
- Memory rule: once `imem_req` is asserted, `imem_req` and `imem_addr` are held stable until `imem_ack`. Requests are never withdrawn, except by reset.
- Bypass: `hit` = REQ & `imem_req` & `imem_ack`.
  - `fetch_valid` = (`buf_valid` | `hit`) & !`pc_src`.
  - `instr` = `buf_valid` ? `buf` : `imem_rdata` when `fetch_valid`; otherwise 32'h0.
- `pc_incr` = `pc` + 32'd4, combinational, wraps modulo 2^32 (32'hFFFF_FFFC gives 0).
- Per-edge priority:
  1. `pc_src`=1:
     - `pc` <= `branch_target`; `buf_valid` <= 0.
     - If REQ with an outstanding request and no `imem_ack`, then `drain_addr` <= `pc` and go to DRAIN. Otherwise stay in (or go to) REQ.
     - Overrides `en_IF` and any concurrent ack.
  2. `fetch_valid` & `en_IF`: instruction consumed.
     - `pc` <= `pc`+4; `buf_valid` <= 0.
  3. `hit` & !`en_IF`:
     - `buf` <= `imem_rdata`; `buf_valid` <= 1.
     - `pc` holds; no new request until consumed.
  4. DRAIN & `imem_ack`: go to REQ; new request at `pc` (the redirect target) next cycle.
- `pc_src` arriving during DRAIN only updates `pc`; the drain continues.
- `en_IF`=0 with `buf_valid`=1 holds `instr`/`pc_incr` stable indefinitely.

## Timing
- Reset (`rst`=0, async):
  - FSM=IDLE, `pc`=`RESET_PC`, `buf_valid`=0, `buf`=0, `drain_addr`=0.
  - Outputs: `imem_req`=0, `fetch_valid`=0, `instr`=0, `pc_incr`=`RESET_PC`+4.
- First request: cycle 1 after `rst` rises. With zero-wait memory, the first valid instruction also appears in cycle 1.
- Throughput: 1 instruction/cycle with zero-wait memory (ack in the request cycle). With N wait states, 1 per N+1 cycles.
- Latency: `imem_rdata` to `instr` is combinational on a hit and registered via `buf` on a stall.
- Redirect penalty:
  - 0 extra cycles if no request is outstanding. The target request issues the cycle after `pc_src`.
  - Otherwise the remaining drain wait plus 1 cycle.
- Reset mid-request drops the request. Memory tolerates an abandoned request.

## Test plan
- Zero-wait stream, `RESET_PC`=0, ack every cycle, `en_IF`=1 -> `imem_addr` 0,4,8,12 on consecutive cycles; `instr` equals `imem_rdata` same cycle; `pc_incr` 4,8,12,16; `fetch_valid`=1 from cycle 1.
- Two wait states per request -> `imem_req` held at the same address for 3 cycles; `fetch_valid`=0 and `instr`=0 for 2 cycles, then 1 for the ack cycle.
- Ack at addr 8 with `en_IF`=0 for 3 cycles -> `instr`=word@8 and `pc_incr`=12 held stable; `imem_req`=0; on `en_IF`=1 the request for 12 issues next cycle.
- `pc_src`=1, target 32'h100, while addr 0x20 is waiting (ack 2 cycles later) -> DRAIN keeps addr 0x20 until ack; that data is discarded (`fetch_valid`=0); then request 0x100; `pc_incr`=0x104.
- `pc_src`=1 coincident with ack and `en_IF`=1 -> `fetch_valid`=0, `instr`=0; next request at `branch_target`; no PC+4 advance.
- `rst` pulled low mid-wait -> `imem_req`, `fetch_valid` and `instr` drop to 0 immediately; after release the request restarts at `RESET_PC`; `pc_incr` at 32'hFFFF_FFFC reads 0.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/ack fetch
// to instruction memory, and presents instr/pc_incr (or a NOP bubble) to IF/ID.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_IF,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc_incr,
    output logic        fetch_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic [31:0] buf_q;
    logic        buf_valid;
    logic [31:0] drain_addr;
    logic        hit;
    logic        stuck_req;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        imem_req  = 1'b0;
        imem_addr = pc;
        state_nxt = state;
        unique case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                imem_req = !buf_valid;
                // A redirect that catches an un-acked request must let it finish first.
                if (pc_src && imem_req && !imem_ack) state_nxt = DRAIN;
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
                if (imem_ack) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign hit         = (state == REQ) && imem_req && imem_ack;
    assign stuck_req   = (state == REQ) && imem_req && !imem_ack;
    assign fetch_valid = (buf_valid || hit) && !pc_src;
    assign instr       = !fetch_valid ? 32'h0 : (buf_valid ? buf_q : imem_rdata);
    assign pc_incr     = pc + 32'd4;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: buf is a single word, not a memory array, so it is cleared on reset like any other register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_PC;
            buf_q      <= 32'h0;
            buf_valid  <= 1'b0;
            drain_addr <= 32'h0;
        end else if (pc_src) begin
            pc        <= branch_target;
            buf_valid <= 1'b0;
            if (stuck_req) drain_addr <= pc;
        end else if (fetch_valid && en_IF) begin
            pc        <= pc_incr;
            buf_valid <= 1'b0;
        end else if (hit && !en_IF) begin
            buf_q     <= imem_rdata;
            buf_valid <= 1'b1;
        end
    end

endmodule
